// File: rtl/sprite_pkg.sv
// ---------------------------------------------------------------------------
// sprite_pkg
// Shared types and defaults for the sprite layer scheduler slice.
//   DEF_NUM_LAYERS  default number of sprite layers (layer 0 = player)
//   DEF_TRANSP_IDX  default chroma-key palette index
//   DEF_CNT_W       default collision counter width
//   rgb24_t         packed {R,G,B} colour
//   pal_idx_t       4-bit shared palette index
//   lyr_id_t        layer id wide enough to also encode "background"
// ---------------------------------------------------------------------------
package sprite_pkg;

  localparam int         DEF_NUM_LAYERS = 4;
  localparam logic [3:0] DEF_TRANSP_IDX = 4'h1;
  localparam int         DEF_CNT_W      = 16;

  typedef logic [23:0] rgb24_t;
  typedef logic [3:0]  pal_idx_t;

  // One extra bit beyond the layer index so the value NUM_LAYERS can
  // stand for "no layer won, background shown".
  function automatic int layerIdWidth(input int numLayers);
    return $clog2(numLayers) + 1;
  endfunction

  typedef logic [layerIdWidth(DEF_NUM_LAYERS)-1:0] lyr_id_t;

endpackage

// File: rtl/sprite_prio_select.sv
// ---------------------------------------------------------------------------
// sprite_prio_select
// Purely combinational: builds the opaque mask (layer covers the pixel and
// its index is not the chroma key), picks the lowest-numbered opaque layer
// and flags a layer-0 collision.
//   valid_i   per-layer coverage, already gated by the active enable mask
//   idx_i     per-layer palette index, layer i at [4i+3:4i]
//   hit_o     at least one layer is opaque
//   winId_o   lowest opaque layer (0 when no hit)
//   winIdx_o  palette index of that layer (0 when no hit)
//   coll_o    layer 0 opaque together with any other opaque layer
// ---------------------------------------------------------------------------
module sprite_prio_select
  import sprite_pkg::*;
#(
  parameter int         NUM_LAYERS = DEF_NUM_LAYERS,
  parameter logic [3:0] TRANSP_IDX = DEF_TRANSP_IDX,
  parameter int         ID_W       = layerIdWidth(DEF_NUM_LAYERS)
) (
  input  logic [NUM_LAYERS-1:0]   valid_i,
  input  logic [4*NUM_LAYERS-1:0] idx_i,
  output logic                    hit_o,
  output logic [ID_W-1:0]         winId_o,
  output pal_idx_t                winIdx_o,
  output logic                    coll_o
);

  logic [NUM_LAYERS-1:0] opaque;

  // A layer only competes when it covers the pixel with a non-key colour.
  always_comb begin
    opaque = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      opaque[i] = valid_i[i] && (idx_i[4*i +: 4] != TRANSP_IDX);
    end
  end

  // Scanning from the top down lets the lowest opaque layer overwrite any
  // higher one, which gives layer 0 the final say.
  always_comb begin
    hit_o    = |opaque;
    winId_o  = '0;
    winIdx_o = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        winId_o  = ID_W'(i);
        winIdx_o = idx_i[4*i +: 4];
      end
    end
  end

  assign coll_o = opaque[0] && (|opaque[NUM_LAYERS-1:1]);

endmodule

// File: rtl/sprite_layer_scheduler.sv
// ---------------------------------------------------------------------------
// sprite_layer_scheduler
// Per-pixel compositor for the shared sprite palette. Three-stage pipeline:
//   S1 registers the incoming pixel with the layer-enable mask applied,
//   S2 resolves priority/transparency and detects layer-0 collisions,
//   S3 drives the external palette lookup and registers the RGB result.
// Ports:
//   Clk, Reset_n              clock, asynchronous active-low reset
//   frame_start               one-cycle pulse at the first pixel of a frame
//   pix_valid                 active-video pixel strobe
//   lyr_valid, lyr_idx        per-layer coverage and palette index
//   bg_rgb                    colour shown when no layer is opaque
//   cfg_valid/cfg_mask        layer-enable update request, cfg_ready accepts
//   pal_idx -> pal_rgb        shared palette, combinational return
//   rgb_out/rgb_valid         composited pixel, 3 cycles after pix_valid
//   owner_id                  winning layer, NUM_LAYERS for background
//   coll_count                layer-0 collisions seen in the previous frame
// ---------------------------------------------------------------------------
module sprite_layer_scheduler
  import sprite_pkg::*;
#(
  parameter int         NUM_LAYERS = DEF_NUM_LAYERS,
  parameter logic [3:0] TRANSP_IDX = DEF_TRANSP_IDX,
  parameter int         CNT_W      = DEF_CNT_W
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          frame_start,
  input  logic                          pix_valid,
  input  logic [NUM_LAYERS-1:0]         lyr_valid,
  input  logic [4*NUM_LAYERS-1:0]       lyr_idx,
  input  rgb24_t                        bg_rgb,
  input  logic                          cfg_valid,
  input  logic [NUM_LAYERS-1:0]         cfg_mask,
  output logic                          cfg_ready,
  output pal_idx_t                      pal_idx,
  input  rgb24_t                        pal_rgb,
  output rgb24_t                        rgb_out,
  output logic                          rgb_valid,
  output logic [$clog2(NUM_LAYERS):0]   owner_id,
  output logic [CNT_W-1:0]              coll_count
);

  localparam int              ID_W  = layerIdWidth(NUM_LAYERS);
  localparam logic [ID_W-1:0] BG_ID = ID_W'(NUM_LAYERS);

  // Layer-enable configuration
  logic [NUM_LAYERS-1:0] activeMask_q, activeMask_d;
  logic [NUM_LAYERS-1:0] shadowMask_q, shadowMask_d;
  logic                  pending_q, pending_d;
  logic                  cfgCapture;
  logic [NUM_LAYERS-1:0] frameMask;
  logic [NUM_LAYERS-1:0] s1Mask;

  // Pipeline stages
  logic                    s1Valid_q;
  logic [NUM_LAYERS-1:0]   s1Lyr_q;
  logic [4*NUM_LAYERS-1:0] s1Idx_q;
  rgb24_t                  s1Bg_q;

  logic                    selHit;
  logic [ID_W-1:0]         selId;
  pal_idx_t                selIdx;
  logic                    selColl;

  logic                    s2Valid_q;
  logic                    s2Hit_q;
  logic [ID_W-1:0]         s2Id_q;
  pal_idx_t                s2Idx_q;
  rgb24_t                  s2Bg_q;

  rgb24_t                  rgbOut_q;
  logic                    rgbValid_q;
  logic [ID_W-1:0]         ownerId_q;

  // Collision counting
  logic [CNT_W-1:0]        running_q, running_d;
  logic [CNT_W-1:0]        collCount_q, collCount_d;
  logic [CNT_W-1:0]        runAtEdge;
  logic                    collInc;

  assign cfg_ready  = !pending_q;
  assign cfgCapture = cfg_valid && cfg_ready;

  // The mask taking effect at a frame boundary: a request captured in the
  // same cycle wins, otherwise whatever sits in the shadow register (which
  // equals the active mask when nothing is pending).
  assign frameMask = cfgCapture ? cfg_mask : shadowMask_q;

  // The first pixel of a frame arrives with frame_start, so it must already
  // see the new mask rather than last frame's.
  assign s1Mask = frame_start ? frameMask : activeMask_q;

  // Next-state for the configuration handshake. Pending blocks new requests
  // until the frame boundary so the mask never changes mid-frame.
  always_comb begin
    activeMask_d = activeMask_q;
    shadowMask_d = shadowMask_q;
    pending_d    = pending_q;
    if (cfgCapture) begin
      shadowMask_d = cfg_mask;
    end
    if (frame_start) begin
      activeMask_d = frameMask;
      pending_d    = 1'b0;
    end else if (cfgCapture) begin
      pending_d    = 1'b1;
    end
  end

  // Configuration registers come out of reset with every layer enabled.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      activeMask_q <= '1;
      shadowMask_q <= '1;
      pending_q    <= 1'b0;
    end else begin
      activeMask_q <= activeMask_d;
      shadowMask_q <= shadowMask_d;
      pending_q    <= pending_d;
    end
  end

  // S1: capture the pixel with disabled layers already masked off.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1Valid_q <= 1'b0;
      s1Lyr_q   <= '0;
      s1Idx_q   <= '0;
      s1Bg_q    <= '0;
    end else begin
      s1Valid_q <= pix_valid;
      s1Lyr_q   <= lyr_valid & s1Mask;
      s1Idx_q   <= lyr_idx;
      s1Bg_q    <= bg_rgb;
    end
  end

  sprite_prio_select #(
    .NUM_LAYERS (NUM_LAYERS),
    .TRANSP_IDX (TRANSP_IDX),
    .ID_W       (ID_W)
  ) u_prioSelect (
    .valid_i  (s1Lyr_q),
    .idx_i    (s1Idx_q),
    .hit_o    (selHit),
    .winId_o  (selId),
    .winIdx_o (selIdx),
    .coll_o   (selColl)
  );

  // S2: hold the priority decision for the palette lookup stage.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s2Valid_q <= 1'b0;
      s2Hit_q   <= 1'b0;
      s2Id_q    <= '0;
      s2Idx_q   <= '0;
      s2Bg_q    <= '0;
    end else begin
      s2Valid_q <= s1Valid_q;
      s2Hit_q   <= selHit;
      s2Id_q    <= selId;
      s2Idx_q   <= selIdx;
      s2Bg_q    <= s1Bg_q;
    end
  end

  assign pal_idx = s2Hit_q ? s2Idx_q : '0;

  // S3: bubbles leave rgb_out and owner_id untouched and only drop rgb_valid.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgbOut_q   <= '0;
      rgbValid_q <= 1'b0;
      ownerId_q  <= BG_ID;
    end else begin
      rgbValid_q <= s2Valid_q;
      if (s2Valid_q) begin
        rgbOut_q  <= s2Hit_q ? pal_rgb : s2Bg_q;
        ownerId_q <= s2Hit_q ? s2Id_q : BG_ID;
      end
    end
  end

  assign rgb_out   = rgbOut_q;
  assign rgb_valid = rgbValid_q;
  assign owner_id  = ownerId_q;

  // Collisions are counted as a valid pixel is resolved in S2. The frame
  // snapshot includes a collision resolved in the frame_start cycle itself;
  // pixels still in S1 land in the new frame.
  assign collInc   = s1Valid_q && selColl;
  assign runAtEdge = (collInc && (running_q != '1)) ? running_q + CNT_W'(1) : running_q;

  always_comb begin
    running_d   = runAtEdge;
    collCount_d = collCount_q;
    if (frame_start) begin
      running_d   = '0;
      collCount_d = runAtEdge;
    end
  end

  // Running and snapshot collision counters.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      running_q   <= '0;
      collCount_q <= '0;
    end else begin
      running_q   <= running_d;
      collCount_q <= collCount_d;
    end
  end

  assign coll_count = collCount_q;

endmodule

// File: tb/tb_sprite_layer_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sprite_layer_scheduler
// Self-checking bench for sprite_layer_scheduler. A behavioural model
// predicts each composited pixel (owner, colour, arrival cycle) into a
// scoreboard queue and tracks collision events by the cycle they land in a
// frame; a monitor on the falling edge compares the DUT against it.
// ---------------------------------------------------------------------------
module tb_sprite_layer_scheduler;

  localparam int         NL     = 4;
  localparam logic [3:0] TRANSP = 4'h1;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [3:0]  lyr_valid = '0;
  logic [15:0] lyr_idx = '0;
  logic [23:0] bg_rgb = '0;
  logic        cfg_valid = 1'b0;
  logic [3:0]  cfg_mask = '0;
  logic        cfg_ready;
  logic [3:0]  pal_idx;
  logic [23:0] pal_rgb;
  logic [23:0] rgb_out;
  logic        rgb_valid;
  logic [2:0]  owner_id;
  logic [15:0] coll_count;

  always #5 Clk = ~Clk;

  sprite_layer_scheduler dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .lyr_valid   (lyr_valid),
    .lyr_idx     (lyr_idx),
    .bg_rgb      (bg_rgb),
    .cfg_valid   (cfg_valid),
    .cfg_mask    (cfg_mask),
    .cfg_ready   (cfg_ready),
    .pal_idx     (pal_idx),
    .pal_rgb     (pal_rgb),
    .rgb_out     (rgb_out),
    .rgb_valid   (rgb_valid),
    .owner_id    (owner_id),
    .coll_count  (coll_count)
  );

  // Stand-in palette: every index maps to a distinct, easily recognised colour.
  function automatic logic [23:0] palColor(input logic [3:0] idx);
    return {idx, 4'h7, ~idx, 4'hC, idx ^ 4'h5, 4'h2};
  endfunction

  assign pal_rgb = palColor(pal_idx);

  typedef struct {
    int          due;
    logic [2:0]  owner;
    logic [23:0] rgb;
  } item_t;

  item_t       scoreQ[$];
  int          collEv[$];
  int          cyc = 0;
  int          vectorCount = 0;
  int          missCount = 0;
  int          validSeen = 0;
  bit          monOn = 1'b0;
  logic [23:0] lastRgb = '0;
  logic [3:0]  mActive = 4'hF;
  logic [3:0]  mPendMask = 4'hF;
  bit          mPending = 1'b0;
  int          mFrameColl = 0;
  logic [15:0] expColl = '0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Forget everything in flight and return the model to its post-reset view.
  task automatic resetModel();
    scoreQ.delete();
    collEv.delete();
    mActive    = 4'hF;
    mPendMask  = 4'hF;
    mPending   = 1'b0;
    mFrameColl = 0;
    lastRgb    = '0;
  endtask

  // Drives one clock cycle of inputs and advances the reference model.
  task automatic applyStimulus(input bit pv, input logic [3:0] lv, input logic [15:0] idx,
                               input logic [23:0] bg, input bit fs, input bit cv,
                               input logic [3:0] cm);
    logic [3:0] mask;
    logic [3:0] opq;
    bit         capture;
    int         win;
    item_t      it;
    @(negedge Clk);
    pix_valid   = pv;
    lyr_valid   = lv;
    lyr_idx     = idx;
    bg_rgb      = bg;
    frame_start = fs;
    cfg_valid   = cv;
    cfg_mask    = cm;
    checkOutput("cfg_ready", {31'd0, cfg_ready}, {31'd0, !mPending});
    capture = cv && !mPending;
    mask = fs ? (capture ? cm : (mPending ? mPendMask : mActive)) : mActive;

    // Collisions resolved up to and including the coming edge belong to
    // the frame that frame_start closes.
    while (collEv.size() > 0 && collEv[0] <= cyc + 1) begin
      void'(collEv.pop_front());
      if (mFrameColl < 65535) mFrameColl++;
    end
    if (fs) begin
      expColl    = mFrameColl[15:0];
      mFrameColl = 0;
      mActive    = mask;
      mPending   = 1'b0;
    end else if (capture) begin
      mPendMask = cm;
      mPending  = 1'b1;
    end

    if (pv) begin
      win = NL;
      for (int i = NL - 1; i >= 0; i--) begin
        opq[i] = lv[i] && mask[i] && (idx[4*i +: 4] != TRANSP);
        if (opq[i]) win = i;
      end
      it.due   = cyc + 3;
      it.owner = win[2:0];
      it.rgb   = (win < NL) ? palColor(idx[4*win +: 4]) : bg;
      scoreQ.push_back(it);
      if (opq[0] && (|opq[3:1])) collEv.push_back(cyc + 2);
    end

    @(posedge Clk);
    #1;
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    cfg_valid   = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, '0, '0, '0, 0, 0, '0);
  endtask

  task automatic frameStart(input bit cv, input logic [3:0] cm);
    applyStimulus(0, '0, '0, '0, 1, cv, cm);
    checkOutput("coll_count", {16'd0, coll_count}, {16'd0, expColl});
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rgb_valid"}, {31'd0, rgb_valid}, 32'd0);
    checkOutput({tag, "_owner_id"}, {29'd0, owner_id}, 32'd4);
    checkOutput({tag, "_coll_count"}, {16'd0, coll_count}, 32'd0);
    checkOutput({tag, "_cfg_ready"}, {31'd0, cfg_ready}, 32'd1);
  endtask

  // Falling-edge monitor: every output pixel must arrive exactly on its
  // predicted cycle; between pixels rgb_out must hold.
  always @(negedge Clk) begin
    if (monOn) begin
      bit    expV;
      item_t it;
      while (scoreQ.size() > 0 && scoreQ[0].due < cyc) begin
        checkOutput("pixel_late", cyc, scoreQ[0].due);
        void'(scoreQ.pop_front());
      end
      expV = (scoreQ.size() > 0) && (scoreQ[0].due == cyc);
      checkOutput("rgb_valid", {31'd0, rgb_valid}, {31'd0, expV});
      if (rgb_valid) validSeen++;
      if (rgb_valid && expV) begin
        it = scoreQ.pop_front();
        checkOutput("owner_id", {29'd0, owner_id}, {29'd0, it.owner});
        checkOutput("rgb_out", {8'd0, rgb_out}, {8'd0, it.rgb});
        lastRgb = it.rgb;
      end else if (!rgb_valid) begin
        checkOutput("rgb_hold", {8'd0, rgb_out}, {8'd0, lastRgb});
      end
    end
  end

  function automatic logic [15:0] randIdx();
    logic [15:0] v;
    for (int i = 0; i < NL; i++) v[4*i +: 4] = ($urandom_range(0, 3) == 0) ? TRANSP : 4'($urandom);
    return v;
  endfunction

  initial begin
    int startSeen;

    // Power-up reset, values must appear without a clock edge.
    #1 Reset_n = 1'b0;
    #1 checkResetValues("por");
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    resetModel();
    monOn = 1'b1;

    // Fixed priority: layer 1 beats layer 2, three-cycle latency.
    applyStimulus(1, 4'b0110, 16'h0830, 24'h123456, 0, 0, '0);
    idleCycles(1);
    checkOutput("pal_idx_s3", {28'd0, pal_idx}, 32'd3);
    idleCycles(3);

    // Transparent layers fall through to the background.
    applyStimulus(1, 4'b0011, 16'h0011, 24'h00A0FF, 0, 0, '0);
    idleCycles(4);

    // Ten layer-0 collisions in one frame, none in the next.
    frameStart(0, '0);
    for (int k = 0; k < 10; k++)
      applyStimulus(1, 4'hF, {4'h5, 4'($urandom), 4'($urandom), 4'h2}, 24'($urandom), 0, 0, '0);
    idleCycles(3);
    frameStart(0, '0);
    checkOutput("coll_ten", {16'd0, coll_count}, 32'd10);
    idleCycles(2);
    frameStart(0, '0);

    // Mask update requested mid-frame only takes effect at frame_start.
    applyStimulus(1, 4'b0011, 16'h0032, 24'h0, 0, 1, 4'b1110);
    applyStimulus(1, 4'b0011, 16'h0032, 24'h0, 0, 1, 4'b0000);
    applyStimulus(1, 4'b0011, 16'h0032, 24'h0, 0, 0, '0);
    idleCycles(3);
    frameStart(0, '0);
    applyStimulus(1, 4'b0011, 16'h0032, 24'h0, 0, 0, '0);
    idleCycles(3);
    // Capture and frame_start together: applied at once.
    frameStart(1, 4'b1100);
    applyStimulus(1, 4'hF, 16'h5555, 24'h0, 0, 0, '0);
    idleCycles(3);
    frameStart(1, 4'hF);

    // Throughput: 640 back-to-back random pixels.
    startSeen = validSeen;
    for (int k = 0; k < 640; k++)
      applyStimulus(1, 4'($urandom), randIdx(), 24'($urandom), 0,
                    ($urandom_range(0, 15) == 0), 4'($urandom));
    idleCycles(4);
    checkOutput("throughput", validSeen - startSeen, 32'd640);
    frameStart(0, '0);

    // Random mix with bubbles and frame boundaries while pixels are in flight.
    for (int k = 0; k < 400; k++)
      applyStimulus(($urandom_range(0, 3) != 0), 4'($urandom), randIdx(), 24'($urandom),
                    ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0), 4'($urandom));

    // Asynchronous reset with pixels in flight and an update pending.
    applyStimulus(1, 4'hF, 16'h5432, 24'h0, 0, 1, 4'b1010);
    applyStimulus(1, 4'hF, 16'h5432, 24'h0, 0, 0, '0);
    #2;
    monOn   = 1'b0;
    Reset_n = 1'b0;
    #1 checkResetValues("midrst");
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    resetModel();
    monOn = 1'b1;
    idleCycles(5);
    applyStimulus(1, 4'hF, 16'h5432, 24'h0, 0, 0, '0);
    idleCycles(4);

    checkOutput("queue_drained", scoreQ.size(), 32'd0);
    monOn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
